// File: rtl/glip_uart_rx_decode.sv
// glip_uart_rx_decode: byte-stuffed UART link decoder with data FIFO, credit/reset escapes and error counters
module glip_uart_rx_decode #(
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] ESC        = 8'hFE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_enable,
  input  logic [7:0]  in_data,
  input  logic        in_error,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        credit_valid,
  output logic [14:0] credit_value,
  output logic        ctrl_reset,
  input  logic        err_clear,
  output logic [7:0]  frame_err_cnt,
  output logic [7:0]  overflow_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {DATA, ESCAPED, CREDIT_LO} state_t;
  state_t state, state_n;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, rptr_n;
  logic [6:0] hi;
  logic push, hi_load, cred, creq, pop, full, push_ok, drop;
  always_comb begin
    state_n = state;
    push = 1'b0;
    hi_load = 1'b0;
    cred = 1'b0;
    creq = 1'b0;
    if (in_error) state_n = DATA;
    else if (in_enable)
      case (state)
        DATA: begin
          push = in_data != ESC;
          state_n = push ? DATA : ESCAPED;
        end
        ESCAPED: begin
          push = in_data == ESC;
          hi_load = !in_data[7] && in_data != ESC;
          creq = in_data == 8'h80;
          state_n = hi_load ? CREDIT_LO : DATA;
        end
        default: begin
          cred = 1'b1;
          state_n = DATA;
        end
      endcase
  end
  assign out_valid = wptr != rptr;
  assign full = wptr == {~rptr[AW], rptr[AW-1:0]};
  assign pop = out_valid & out_ready;
  assign push_ok = push & (!full | pop);
  assign drop = push & full & !pop;
  assign rptr_n = rptr + {{AW{1'b0}}, pop};
  always_ff @(posedge clk)
    if (push_ok) mem[wptr[AW-1:0]] <= in_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= DATA;
      wptr <= '0;
      rptr <= '0;
      out_data <= '0;
      hi <= '0;
      credit_valid <= 1'b0;
      credit_value <= '0;
      ctrl_reset <= 1'b0;
      frame_err_cnt <= '0;
      overflow_cnt <= '0;
    end else begin
      state <= state_n;
      wptr <= wptr + {{AW{1'b0}}, push_ok};
      rptr <= rptr_n;
      // head register follows the entry that becomes the head after this edge
      out_data <= rptr_n == wptr ? (push_ok ? in_data : out_data) : mem[rptr_n[AW-1:0]];
      hi <= hi_load ? in_data[6:0] : hi;
      credit_valid <= cred;
      credit_value <= cred ? {hi, in_data} : credit_value;
      ctrl_reset <= creq;
      frame_err_cnt <= err_clear ? '0 : frame_err_cnt + 8'(in_error && frame_err_cnt != 8'hFF);
      overflow_cnt <= err_clear ? '0 : overflow_cnt + 8'(drop && overflow_cnt != 8'hFF);
    end
endmodule

// File: tb/tb_glip_uart_rx_decode.sv
// tb_glip_uart_rx_decode: vector table plus scoreboard bench for the UART link decoder
module tb_glip_uart_rx_decode;
  logic clk = 0, rst = 0, in_enable = 0, in_error = 0, out_ready = 0, err_clear = 0;
  logic [7:0] in_data = 0;
  logic [7:0] out_data, frame_err_cnt, overflow_cnt;
  logic out_valid, credit_valid, ctrl_reset;
  logic [14:0] credit_value;
  int total = 0, bad = 0;
  logic [7:0] sb [$];

  typedef struct packed {
    logic en;
    logic err;
    logic [7:0] d;
    logic push;
    logic cv;
    logic [14:0] cval;
    logic cr;
  } vec_t;
  vec_t tbl [$];

  glip_uart_rx_decode dut (
    .clk(clk), .rst(rst), .in_enable(in_enable), .in_data(in_data), .in_error(in_error),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .credit_valid(credit_valid), .credit_value(credit_value), .ctrl_reset(ctrl_reset),
    .err_clear(err_clear), .frame_err_cnt(frame_err_cnt), .overflow_cnt(overflow_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %0h expected no output", out_data);
      end else check("out_data", out_data, sb.pop_front());
    end

  function automatic vec_t mk(input logic en, input logic err, input logic [7:0] d,
                              input logic push, input logic cv, input logic [14:0] cval, input logic cr);
    mk = {en, err, d, push, cv, cval, cr};
  endfunction

  task automatic send(input vec_t v);
    @(posedge clk); #1;
    if (v.push && out_ready) check("pre_valid", out_valid, 0);
    in_enable = v.en;
    in_error = v.err;
    in_data = v.d;
    @(posedge clk); #1;
    in_enable = 0;
    in_error = 0;
    if (v.push) begin
      sb.push_back(v.d);
      if (out_ready) check("lat_valid", out_valid, 1);
    end
    check("credit_valid", credit_valid, v.cv);
    check("ctrl_reset", ctrl_reset, v.cr);
    if (v.cv) check("credit_value", credit_value, v.cval);
    @(posedge clk); #1;
    check("credit_pulse_end", credit_valid, 0);
    check("ctrl_pulse_end", ctrl_reset, 0);
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1 check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    tbl.push_back(mk(1, 0, 8'h41, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h42, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h43, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hFE, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hFE, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h7A, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hFE, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h12, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h34, 0, 1, 15'h1234, 0));
    tbl.push_back(mk(1, 0, 8'hFE, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h80, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 8'hFE, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h81, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hFE, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hFF, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h22, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hFE, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h12, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'hFE, 0, 1, 15'h12FE, 0));
    tbl.push_back(mk(1, 0, 8'hFE, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h05, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h55, 1, 0, 0, 0));

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_credit_valid", credit_valid, 0);
    check("rst_credit_value", credit_value, 0);
    check("rst_ctrl_reset", ctrl_reset, 0);
    check("rst_frame_err", frame_err_cnt, 0);
    check("rst_overflow", overflow_cnt, 0);
    rst = 1;
    out_ready = 1;

    foreach (tbl[i]) begin
      send(tbl[i]);
      repeat (5) @(posedge clk);
    end
    drain(4);
    check("frame_err_one", frame_err_cnt, 1);

    @(posedge clk); #1 err_clear = 1;
    @(posedge clk); #1 err_clear = 0;
    check("err_clear", frame_err_cnt, 0);
    err_clear = 1;
    in_error = 1;
    @(posedge clk); #1;
    err_clear = 0;
    in_error = 0;
    check("clear_priority", frame_err_cnt, 0);

    out_ready = 0;
    for (int i = 0; i < 19; i++) send(mk(1, 0, 8'(i), i < 16, 0, 0, 0));
    check("overflow_cnt", overflow_cnt, 3);
    check("full_valid", out_valid, 1);
    check("stall_head", out_data, 0);
    @(posedge clk); #1;
    out_ready = 1;
    in_enable = 1;
    in_data = 8'h99;
    sb.push_back(8'h99);
    @(posedge clk); #1;
    in_enable = 0;
    check("full_push_pop_ovf", overflow_cnt, 3);
    drain(30);

    out_ready = 0;
    for (int i = 1; i <= 4; i++) send(mk(1, 0, 8'(i), 1, 0, 0, 0));
    send(mk(1, 0, 8'hFE, 0, 0, 0, 0));
    send(mk(1, 0, 8'h12, 0, 0, 0, 0));
    @(posedge clk); #3;
    rst = 0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_data", out_data, 0);
    check("arst_credit_value", credit_value, 0);
    check("arst_overflow", overflow_cnt, 0);
    check("arst_frame_err", frame_err_cnt, 0);
    check("arst_credit_valid", credit_valid, 0);
    check("arst_ctrl_reset", ctrl_reset, 0);
    sb.delete();
    #3 rst = 1;
    out_ready = 1;
    send(mk(1, 0, 8'h34, 1, 0, 0, 0));
    drain(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
